// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scanner with press/release debounce and one event per key press.
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-high reset
//   synchrows  - synchronized row inputs, 1 = pressed
//   synch_done - row synchronizer has settled on the current column
//   WE_synch   - synchronizer enable; held low after each column change to clear it
//   cols       - one-hot column drive
//   key_valid  - one-cycle pulse per accepted key event
//   key_code   - {row_idx, col_idx} of the last accepted key
//   key_held   - high from accepted press until release is debounced
// Build option: define KEYPAD_REPEAT_EN to re-pulse key_valid every REPEAT_CYCLES while held.
module keypad_scan_ctrl #(
    parameter int SETTLE_CYCLES   = 2,
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int REPEAT_CYCLES   = 6000000,
    parameter int CNT_W           = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] synchrows,
    input  logic       synch_done,
    output logic       WE_synch,
    output logic [3:0] cols,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);
    typedef enum logic [2:0] {SETTLE, SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
    // The sample that detects a key counts as the first stable sample, so the
    // debounce states finish one count early to total DEBOUNCE_CYCLES samples.
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 2);
`ifdef KEYPAD_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST    = CNT_W'(REPEAT_CYCLES - 1);
`endif
    state_t           state, state_n;
    logic [1:0]       col_idx, col_n, row_idx, row_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic             kv_n, held_n, one_hot, row_bit;
    logic [3:0]       row_oh;
    logic [1:0]       row_enc;
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    assign row_oh  = 4'b0001 << row_idx;
    assign row_bit = synchrows[row_idx];
    // True for zero as well; the all-zero case is handled before it is used.
    assign one_hot = (synchrows & (synchrows - 4'd1)) == 4'd0;
    assign row_enc = synchrows[3] ? 2'd3 : synchrows[2] ? 2'd2 : synchrows[1] ? 2'd1 : 2'd0;
    always_comb begin
        state_n = state;
        col_n   = col_idx;
        row_n   = row_idx;
        cnt_n   = cnt;
        kv_n    = 1'b0;
        held_n  = key_held;
        case (state)
            SETTLE: begin
                cnt_n = cnt_inc;
                if (cnt >= SETTLE_LAST) begin
                    cnt_n   = '0;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (synch_done) begin
                    if (synchrows == 4'd0 || !one_hot) begin
                        col_n   = col_idx + 2'd1;
                        state_n = SETTLE;
                    end else begin
                        row_n   = row_enc;
                        cnt_n   = '0;
                        state_n = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (synchrows != row_oh) begin
                    col_n   = col_idx + 2'd1;
                    cnt_n   = '0;
                    state_n = SETTLE;
                end else if (cnt >= DEB_LAST) begin
                    kv_n    = 1'b1;
                    held_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = PRESSED;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            PRESSED: begin
                if (!row_bit) begin
                    cnt_n   = '0;
                    state_n = RELEASE;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (cnt >= REP_LAST) begin
                    kv_n  = 1'b1;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
`endif
            end
            RELEASE: begin
                if (row_bit) begin
                    cnt_n   = '0;
                    state_n = PRESSED;
                end else if (cnt >= DEB_LAST) begin
                    held_n  = 1'b0;
                    col_n   = col_idx + 2'd1;
                    cnt_n   = '0;
                    state_n = SETTLE;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = SETTLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SETTLE;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            cnt       <= '0;
            cols      <= 4'b0001;
            WE_synch  <= 1'b0;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            col_idx   <= col_n;
            row_idx   <= row_n;
            cnt       <= cnt_n;
            cols      <= 4'b0001 << col_n;
            WE_synch  <= state_n != SETTLE;
            key_valid <= kv_n;
            key_code  <= kv_n ? {row_n, col_n} : key_code;
            key_held  <= held_n;
        end
    end
endmodule
